// File: rtl/uc2_hazard_pipe.sv
// UC2 control-path tag pipeline.
// Carries register-access tags from decode through stages 3, 4 and 5 for the
// H2 hazard detector. On H2 it freezes stage 3 and puts a bubble into stage 4.
// A flush squashes whatever would enter stage 3, and it takes priority over a
// stall. The block also keeps a saturating count of stall cycles and a sticky
// watchdog flag for stalls that run too long.
// H2 reaches only hold2 combinationally. Every other output comes straight from
// a flop, so the loop through the external detector is broken here.

module uc2_hazard_pipe #(
    parameter int REG_W     = 6,
    parameter int CNT_W     = 8,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             valid2,
    input  logic             w_read2,
    input  logic             w_write2,
    input  logic             r_read2,
    input  logic             r_write2,
    input  logic [REG_W-1:0] busA2,
    input  logic [REG_W-1:0] busC2,

    input  logic             H2,
    input  logic             flush,

    output logic             w_read3,
    output logic             w_write3,
    output logic             r_read3,
    output logic             r_write3,
    output logic [REG_W-1:0] busA3,
    output logic [REG_W-1:0] busC3,

    output logic             w_read4,
    output logic             w_write4,
    output logic             r_read4,
    output logic             r_write4,
    output logic [REG_W-1:0] busC4,

    output logic             w_read5,
    output logic             w_write5,
    output logic             r_read5,
    output logic             r_write5,
    output logic [REG_W-1:0] busC5,

    output logic             hold2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);

    // The run counter only has to reach MAX_STALL; it saturates there.
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    logic             stall_edge;
    logic             tag2_live;
    logic             load3;
    logic [RUN_W-1:0] run_cnt;

    // Stall is only a real stall when no flush is redirecting the stream.
    assign stall_edge = H2 & ~flush;
    assign hold2      = stall_edge;

    // A decode slot with no access flags is a bubble. Its buses load as zero.
    assign tag2_live  = valid2 & (w_read2 | w_write2 | r_read2 | r_write2);
    assign load3      = ~flush & ~H2;

    // Stage 3: flush squashes it, stall freezes it, otherwise it takes decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_read3  <= 1'b0;
            w_write3 <= 1'b0;
            r_read3  <= 1'b0;
            r_write3 <= 1'b0;
            busA3    <= '0;
            busC3    <= '0;
        end else if (flush) begin
            w_read3  <= 1'b0;
            w_write3 <= 1'b0;
            r_read3  <= 1'b0;
            r_write3 <= 1'b0;
            busA3    <= '0;
            busC3    <= '0;
        end else if (load3) begin
            w_read3  <= tag2_live & w_read2;
            w_write3 <= tag2_live & w_write2;
            r_read3  <= tag2_live & r_read2;
            r_write3 <= tag2_live & r_write2;
            busA3    <= tag2_live ? busA2 : '0;
            busC3    <= tag2_live ? busC2 : '0;
        end
    end

    // Stage 4: a bubble whenever H2 is high. That covers a plain stall, and also
    // flush with H2, where stage 3 must not move forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_read4  <= 1'b0;
            w_write4 <= 1'b0;
            r_read4  <= 1'b0;
            r_write4 <= 1'b0;
            busC4    <= '0;
        end else if (H2) begin
            w_read4  <= 1'b0;
            w_write4 <= 1'b0;
            r_read4  <= 1'b0;
            r_write4 <= 1'b0;
            busC4    <= '0;
        end else begin
            w_read4  <= w_read3;
            w_write4 <= w_write3;
            r_read4  <= r_read3;
            r_write4 <= r_write3;
            busC4    <= busC3;
        end
    end

    // Stage 5: always drains stage 4 and retires every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_read5  <= 1'b0;
            w_write5 <= 1'b0;
            r_read5  <= 1'b0;
            r_write5 <= 1'b0;
            busC5    <= '0;
        end else begin
            w_read5  <= w_read4;
            w_write5 <= w_write4;
            r_read5  <= r_read4;
            r_write5 <= r_write4;
            busC5    <= busC4;
        end
    end

    // Total stall cycles since reset. It holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_edge && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Watchdog. When a stall edge arrives after MAX_STALL consecutive stall
    // edges, the error latches and stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt   <= '0;
            stall_err <= 1'b0;
        end else if (stall_edge) begin
            if (run_cnt == RUN_LIMIT) begin
                stall_err <= 1'b1;
            end else begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end else begin
            run_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_uc2_hazard_pipe.sv
// Bench for uc2_hazard_pipe: directed vector table, multi-cycle corner cases,
// then random traffic against a tag-queue reference model.

module tb_uc2_hazard_pipe;

    localparam int REG_W     = 6;
    localparam int MAX_STALL = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic valid2, w_read2, w_write2, r_read2, r_write2;
    logic [REG_W-1:0] busA2, busC2;
    logic H2, flush;

    logic w_read3, w_write3, r_read3, r_write3;
    logic [REG_W-1:0] busA3, busC3;
    logic w_read4, w_write4, r_read4, r_write4;
    logic [REG_W-1:0] busC4;
    logic w_read5, w_write5, r_read5, r_write5;
    logic [REG_W-1:0] busC5;
    logic hold2, stall_err;
    logic [7:0] stall_cnt;

    logic s_w_read3, s_w_write3, s_r_read3, s_r_write3;
    logic [REG_W-1:0] s_busA3, s_busC3;
    logic s_w_read4, s_w_write4, s_r_read4, s_r_write4;
    logic [REG_W-1:0] s_busC4;
    logic s_w_read5, s_w_write5, s_r_read5, s_r_write5;
    logic [REG_W-1:0] s_busC5;
    logic s_hold2, s_stall_err;
    logic [2:0] s_stall_cnt;

    always #5 clk = ~clk;

    uc2_hazard_pipe #(.REG_W(REG_W), .CNT_W(8), .MAX_STALL(MAX_STALL)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .valid2(valid2), .w_read2(w_read2), .w_write2(w_write2),
        .r_read2(r_read2), .r_write2(r_write2), .busA2(busA2), .busC2(busC2),
        .H2(H2), .flush(flush),
        .w_read3(w_read3), .w_write3(w_write3), .r_read3(r_read3), .r_write3(r_write3),
        .busA3(busA3), .busC3(busC3),
        .w_read4(w_read4), .w_write4(w_write4), .r_read4(r_read4), .r_write4(r_write4),
        .busC4(busC4),
        .w_read5(w_read5), .w_write5(w_write5), .r_read5(r_read5), .r_write5(r_write5),
        .busC5(busC5),
        .hold2(hold2), .stall_cnt(stall_cnt), .stall_err(stall_err)
    );

    uc2_hazard_pipe #(.REG_W(REG_W), .CNT_W(3), .MAX_STALL(MAX_STALL)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .valid2(valid2), .w_read2(w_read2), .w_write2(w_write2),
        .r_read2(r_read2), .r_write2(r_write2), .busA2(busA2), .busC2(busC2),
        .H2(H2), .flush(flush),
        .w_read3(s_w_read3), .w_write3(s_w_write3), .r_read3(s_r_read3), .r_write3(s_r_write3),
        .busA3(s_busA3), .busC3(s_busC3),
        .w_read4(s_w_read4), .w_write4(s_w_write4), .r_read4(s_r_read4), .r_write4(s_r_write4),
        .busC4(s_busC4),
        .w_read5(s_w_read5), .w_write5(s_w_write5), .r_read5(s_r_read5), .r_write5(s_r_write5),
        .busC5(s_busC5),
        .hold2(s_hold2), .stall_cnt(s_stall_cnt), .stall_err(s_stall_err)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic             wr;
        logic             ww;
        logic             rr;
        logic             rw;
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] c;
    } tag_t;

    tag_t m_pipe [3];           // index 0 = stage 3, 1 = stage 4, 2 = stage 5
    int   m_total;
    int   m_run;
    bit   m_err;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '0;
        m_total = 0;
        m_run   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        tag_t incoming;
        tag_t old3;
        bit   stall;
        stall = H2 && !flush;
        incoming = '0;
        if (valid2 && (w_read2 || w_write2 || r_read2 || r_write2))
            incoming = '{w_read2, w_write2, r_read2, r_write2, busA2, busC2};
        old3 = m_pipe[0];
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = H2 ? tag_t'('0) : old3;
        if (flush)      m_pipe[0] = '0;
        else if (!H2)   m_pipe[0] = incoming;
        if (stall) begin
            m_total++;
            m_run++;
            if (m_run > MAX_STALL) m_err = 1'b1;
        end else begin
            m_run = 0;
        end
    endtask

    function automatic logic [63:0] exp_vec(input int cnt_max);
        tag_t s4, s5;
        int   cnt;
        s4  = m_pipe[1];
        s5  = m_pipe[2];
        cnt = (m_total > cnt_max) ? cnt_max : m_total;
        if (cnt_max == 255)
            return 64'({m_pipe[0], s4.wr, s4.ww, s4.rr, s4.rw, s4.c,
                        s5.wr, s5.ww, s5.rr, s5.rw, s5.c,
                        (H2 & ~flush), 8'(cnt), m_err});
        else
            return 64'({m_pipe[0], s4.wr, s4.ww, s4.rr, s4.rw, s4.c,
                        s5.wr, s5.ww, s5.rr, s5.rw, s5.c,
                        (H2 & ~flush), 3'(cnt), m_err});
    endfunction

    logic [63:0] act_main, act_sat, act_regs;
    assign act_main = 64'({w_read3, w_write3, r_read3, r_write3, busA3, busC3,
                           w_read4, w_write4, r_read4, r_write4, busC4,
                           w_read5, w_write5, r_read5, r_write5, busC5,
                           hold2, stall_cnt, stall_err});
    assign act_sat  = 64'({s_w_read3, s_w_write3, s_r_read3, s_r_write3, s_busA3, s_busC3,
                           s_w_read4, s_w_write4, s_r_read4, s_r_write4, s_busC4,
                           s_w_read5, s_w_write5, s_r_read5, s_r_write5, s_busC5,
                           s_hold2, s_stall_cnt, s_stall_err});
    // everything registered on the main instance (hold2 excluded)
    assign act_regs = 64'({w_read3, w_write3, r_read3, r_write3, busA3, busC3,
                           w_read4, w_write4, r_read4, r_write4, busC4,
                           w_read5, w_write5, r_read5, r_write5, busC5,
                           stall_cnt, stall_err});

    // ---------------- helpers ----------------
    task automatic drive(input logic v, input logic wr, input logic ww, input logic rr,
                         input logic rw, input logic [REG_W-1:0] a, input logic [REG_W-1:0] c,
                         input logic h, input logic f);
        valid2 = v; w_read2 = wr; w_write2 = ww; r_read2 = rr; r_write2 = rw;
        busA2 = a; busC2 = c; H2 = h; flush = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic             v;
        logic [REG_W-1:0] n;       // instruction uses busA2 = busC2 = n, r_read2 = r_write2 = 1
        logic             h;
        logic             f;
        logic             hold;    // hold2 during the cycle
        logic [REG_W-1:0] a3;
        logic             f3;      // r_read3 / r_write3 after the edge
        logic [REG_W-1:0] c4;
        logic             f4;
        logic [REG_W-1:0] c5;
        logic             f5;
        logic [7:0]       cnt;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic v, input int n, input logic h, input logic f,
                                input logic hold, input int a3, input logic f3,
                                input int c4, input logic f4, input int c5, input logic f5,
                                input int cnt);
        vec_t r;
        r.v = v; r.n = REG_W'(n); r.h = h; r.f = f; r.hold = hold;
        r.a3 = REG_W'(a3); r.f3 = f3; r.c4 = REG_W'(c4); r.f4 = f4;
        r.c5 = REG_W'(c5); r.f5 = f5; r.cnt = 8'(cnt);
        return r;
    endfunction

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0);

        //            v  n  H2 fl hold a3 f3 c4 f4 c5 f5 cnt
        tbl[0]  = mk(1, 5, 0, 0, 0,   5, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 6, 0, 0, 0,   6, 1, 5, 1, 0, 0, 0);
        tbl[2]  = mk(1, 7, 0, 0, 0,   7, 1, 6, 1, 5, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,   0, 0, 7, 1, 6, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 7, 1, 0);
        tbl[5]  = mk(1, 5, 0, 0, 0,   5, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 5, 0, 0, 0,   5, 1, 5, 1, 0, 0, 0);
        tbl[7]  = mk(1, 9, 1, 0, 1,   5, 1, 0, 0, 5, 1, 1);
        tbl[8]  = mk(1, 9, 1, 0, 1,   5, 1, 0, 0, 0, 0, 2);
        tbl[9]  = mk(1, 9, 1, 1, 0,   0, 0, 0, 0, 0, 0, 2);
        tbl[10] = mk(1, 9, 0, 0, 0,   9, 1, 0, 0, 0, 0, 2);
        tbl[11] = mk(1, 10, 0, 1, 0,  0, 0, 9, 1, 0, 0, 2);
        tbl[12] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 9, 1, 2);

        // async reset mid-cycle from an arbitrary non-zero state
        @(negedge clk);
        drive(1, 1, 1, 1, 1, 6'h2a, 6'h15, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_regs", act_regs, 64'd0);
        chk("async_reset_cnt_sat", 64'(s_stall_cnt), 64'd0);
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, 0, 0, tbl[i].v, tbl[i].v, tbl[i].n, tbl[i].n, tbl[i].h, tbl[i].f);
            #1;
            chk($sformatf("tbl%0d_hold2", i), 64'(hold2), 64'(tbl[i].hold));
            tick();
            chk($sformatf("tbl%0d_busA3", i),   64'(busA3),   64'(tbl[i].a3));
            chk($sformatf("tbl%0d_busC3", i),   64'(busC3),   64'(tbl[i].a3));
            chk($sformatf("tbl%0d_flags3", i),  64'({w_read3, w_write3, r_read3, r_write3}),
                64'({2'b00, tbl[i].f3, tbl[i].f3}));
            chk($sformatf("tbl%0d_stage4", i),  64'({r_write4, busC4}), 64'({tbl[i].f4, tbl[i].c4}));
            chk($sformatf("tbl%0d_stage5", i),  64'({r_write5, busC5}), 64'({tbl[i].f5, tbl[i].c5}));
            chk($sformatf("tbl%0d_stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_stall_err", i), 64'(stall_err), 64'd0);
        end

        // watchdog: five consecutive stall edges
        do_reset();
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) chk("wdog_err_after4", 64'(stall_err), 64'd0);
            if (k == 5) chk("wdog_err_after5", 64'(stall_err), 64'd1);
        end
        drive(0, 0, 0, 0, 0, '0, '0, 0, 0);
        tick();
        tick();
        chk("wdog_err_sticky", 64'(stall_err), 64'd1);
        chk("wdog_stall_cnt", 64'(stall_cnt), 64'd5);

        // saturation of the 3-bit counter; the 8-bit one keeps counting
        do_reset();
        drive(0, 0, 0, 0, 0, '0, '0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) chk("sat_cnt_at7", 64'(s_stall_cnt), 64'd7);
            if (k == 8) chk("sat_cnt_nowrap", 64'(s_stall_cnt), 64'd7);
        end
        chk("sat_cnt_after10", 64'(s_stall_cnt), 64'd7);
        chk("main_cnt_after10", 64'(stall_cnt), 64'd10);

        // reset during a stall, then the first edge after release advances normally
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midstall_reset_regs", act_regs, 64'd0);
        chk("midstall_reset_sat", 64'({s_stall_cnt, s_stall_err}), 64'd0);
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 6'd3, 6'd4, 0, 0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_advance", 64'({w_read3, w_write3, r_read3, r_write3, busA3, busC3}),
            64'({4'b0100, 6'd3, 6'd4}));

        // random traffic against the reference model
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            for (int cyc = 0; cyc < 1500; cyc++) begin
                logic h;
                h = ($urandom_range(0, 99) < (H2 ? 75 : 20));
                drive(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), REG_W'($urandom), REG_W'($urandom), h,
                      ($urandom_range(0, 9) == 0));
                #1;
                chk($sformatf("rand%0d_%0d_main", seg, cyc), act_main, exp_vec(255));
                chk($sformatf("rand%0d_%0d_sat", seg, cyc), act_sat, exp_vec(7));
                @(posedge clk);
                model_edge();
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
